// File: rtl/sys_defs_pkg.sv
// Shared bus encodings, tag sizing and requester identifiers for the memory-bus slice.
package sys_defs;

    localparam int unsigned CMD_W    = 2;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned NUM_TAGS = 15;

    localparam int unsigned IC_MAX_OUTST_DEF = 8;
    localparam int unsigned DC_MAX_OUTST_DEF = 8;

    localparam logic [CMD_W-1:0] BUS_NONE  = 2'd0;
    localparam logic [CMD_W-1:0] BUS_LOAD  = 2'd1;
    localparam logic [CMD_W-1:0] BUS_STORE = 2'd2;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    // One bus command as presented to memory.
    typedef struct packed {
        logic [CMD_W-1:0]  command;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_req_t;

    // Bits needed for an outstanding counter that must hold 0..max_outst.
    function automatic int unsigned cnt_width(input int unsigned max_outst);
        return $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Per-tag ownership table: allocate on accept, look up and free on return; a same-cycle set wins.
module mem_tag_owner_table
    import sys_defs::*;
#(
    parameter int unsigned N_TAGS = NUM_TAGS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  req_id_e          alloc_owner,
    input  logic             free_en,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit_c,
    output req_id_e          lookup_owner_c
);

    logic [N_TAGS:1] hit_vec;
    logic [N_TAGS:1] dc_hit_vec;
    logic [N_TAGS:1] clash_vec;

    for (genvar g = 1; g <= N_TAGS; g++) begin : g_entry
        logic valid_q, valid_d;
        logic is_dc_q, is_dc_d;
        logic lookup_sel;
        logic alloc_sel;

        assign lookup_sel = (lookup_tag == TAG_W'(g));
        assign alloc_sel  = alloc_en && (alloc_tag == TAG_W'(g));

        // Free on return first, then let an allocation to the same tag override it.
        always_comb begin
            valid_d = valid_q;
            is_dc_d = is_dc_q;
            if (free_en && lookup_sel) begin
                valid_d = 1'b0;
            end
            if (alloc_sel) begin
                valid_d = 1'b1;
                is_dc_d = (alloc_owner == REQ_DC);
            end
        end

        // Entry state register.
        always_ff @(posedge clock) begin
            if (reset) begin
                valid_q <= 1'b0;
                is_dc_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                is_dc_q <= is_dc_d;
            end
        end

        assign hit_vec[g]    = valid_q && lookup_sel;
        assign dc_hit_vec[g] = valid_q && lookup_sel && is_dc_q;
        assign clash_vec[g]  = valid_q && alloc_sel && !(free_en && lookup_sel);
    end

    assign lookup_hit_c   = |hit_vec;
    assign lookup_owner_c = (|dc_hit_vec) ? REQ_DC : REQ_IC;

    // A tag must not be handed out again while still owned (unless freed this cycle).
    a_no_realloc: assert property (@(posedge clock) disable iff (reset) !(|clash_vec));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between icache fetch misses and the dcache MSHR, and routes returns to their owner.
module mem_bus_arbiter
    import sys_defs::*;
#(
    parameter int unsigned IC_MAX_OUTST = IC_MAX_OUTST_DEF,
    parameter int unsigned DC_MAX_OUTST = DC_MAX_OUTST_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CMD_W-1:0]  ic_command,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [CMD_W-1:0]  dc_command,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_data,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [DATA_W-1:0] mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    output logic [CMD_W-1:0]  proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    output logic [TAG_W-1:0]  ic_response,
    output logic [TAG_W-1:0]  dc_response,
    output logic [TAG_W-1:0]  ic_tag,
    output logic [TAG_W-1:0]  dc_tag,
    output logic [DATA_W-1:0] ret_data,
    output logic              stray_tag
);

    localparam int unsigned IC_CNT_W = cnt_width(IC_MAX_OUTST);
    localparam int unsigned DC_CNT_W = cnt_width(DC_MAX_OUTST);

    logic [IC_CNT_W-1:0] ic_outst_q, ic_outst_d;
    logic [DC_CNT_W-1:0] dc_outst_q, dc_outst_d;
    req_id_e             last_acc_q, last_acc_d;

    logic     ic_elig, dc_elig, dc_store;
    logic     gnt_ic, gnt_dc;
    logic     accept, alloc;
    logic     ret_valid;
    logic     hit;
    req_id_e  hit_owner;
    bus_req_t bus;
    logic     ic_inc, ic_dec, dc_inc, dc_dec;

    // Eligibility and grant; stores bypass both throttling and round-robin.
    always_comb begin
        ic_elig  = (ic_command == BUS_LOAD) && (ic_outst_q < IC_CNT_W'(IC_MAX_OUTST));
        dc_store = (dc_command == BUS_STORE);
        dc_elig  = dc_store ||
                   ((dc_command != BUS_NONE) && (dc_outst_q < DC_CNT_W'(DC_MAX_OUTST)));
        gnt_ic   = 1'b0;
        gnt_dc   = 1'b0;
        if (!reset) begin
            if (dc_store) begin
                gnt_dc = 1'b1;
            end else if (ic_elig && dc_elig) begin
                gnt_ic = (last_acc_q == REQ_DC);
                gnt_dc = (last_acc_q == REQ_IC);
            end else begin
                gnt_ic = ic_elig;
                gnt_dc = dc_elig;
            end
        end
    end

    // Bus command mux.
    always_comb begin
        bus = '0;
        if (gnt_ic) begin
            bus.command = ic_command;
            bus.addr    = ic_addr;
        end else if (gnt_dc) begin
            bus.command = dc_command;
            bus.addr    = dc_addr;
            bus.data    = dc_data;
        end
    end

    assign accept    = (gnt_ic || gnt_dc) && (mem2proc_response != '0);
    assign alloc     = accept && (bus.command == BUS_LOAD);
    assign ret_valid = !reset && (mem2proc_tag != '0);

    mem_tag_owner_table #(
        .N_TAGS (NUM_TAGS)
    ) u_owner_table (
        .clock          (clock),
        .reset          (reset),
        .alloc_en       (alloc),
        .alloc_tag      (mem2proc_response),
        .alloc_owner    (gnt_dc ? REQ_DC : REQ_IC),
        .free_en        (ret_valid),
        .lookup_tag     (mem2proc_tag),
        .lookup_hit_c   (hit),
        .lookup_owner_c (hit_owner)
    );

    // Outputs to memory and both requesters; everything idles while reset is held.
    always_comb begin
        proc2mem_command = bus.command;
        proc2mem_addr    = bus.addr;
        proc2mem_data    = bus.data;
        ic_response      = gnt_ic ? mem2proc_response : '0;
        dc_response      = gnt_dc ? mem2proc_response : '0;
        ic_tag           = (ret_valid && hit && (hit_owner == REQ_IC)) ? mem2proc_tag : '0;
        dc_tag           = (ret_valid && hit && (hit_owner == REQ_DC)) ? mem2proc_tag : '0;
        ret_data         = reset ? '0 : mem2proc_data;
        stray_tag        = ret_valid && !hit;
    end

    // Outstanding counters and round-robin history; simultaneous inc/dec cancel.
    always_comb begin
        ic_inc     = alloc && gnt_ic;
        dc_inc     = alloc && gnt_dc;
        ic_dec     = ret_valid && hit && (hit_owner == REQ_IC);
        dc_dec     = ret_valid && hit && (hit_owner == REQ_DC);
        ic_outst_d = ic_outst_q;
        dc_outst_d = dc_outst_q;
        last_acc_d = last_acc_q;
        if (ic_inc && !ic_dec) ic_outst_d = ic_outst_q + IC_CNT_W'(1);
        if (!ic_inc && ic_dec) ic_outst_d = ic_outst_q - IC_CNT_W'(1);
        if (dc_inc && !dc_dec) dc_outst_d = dc_outst_q + DC_CNT_W'(1);
        if (!dc_inc && dc_dec) dc_outst_d = dc_outst_q - DC_CNT_W'(1);
        if (accept) last_acc_d = gnt_dc ? REQ_DC : REQ_IC;
    end

    // Arbiter state register; last_acc resets to dc so ic wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            ic_outst_q <= '0;
            dc_outst_q <= '0;
            last_acc_q <= REQ_DC;
        end else begin
            ic_outst_q <= ic_outst_d;
            dc_outst_q <= dc_outst_d;
            last_acc_q <= last_acc_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios followed by randomized traffic.
module tb_mem_bus_arbiter;
    import sys_defs::*;

    localparam int IC_MAX = 8;
    localparam int DC_MAX = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CMD_W-1:0]  ic_command = BUS_NONE;
    logic [ADDR_W-1:0] ic_addr = '0;
    logic [CMD_W-1:0]  dc_command = BUS_NONE;
    logic [ADDR_W-1:0] dc_addr = '0;
    logic [DATA_W-1:0] dc_data = '0;
    logic [TAG_W-1:0]  mem2proc_response = '0;
    logic [DATA_W-1:0] mem2proc_data = '0;
    logic [TAG_W-1:0]  mem2proc_tag = '0;
    logic [CMD_W-1:0]  proc2mem_command;
    logic [ADDR_W-1:0] proc2mem_addr;
    logic [DATA_W-1:0] proc2mem_data;
    logic [TAG_W-1:0]  ic_response, dc_response, ic_tag, dc_tag;
    logic [DATA_W-1:0] ret_data;
    logic              stray_tag;

    mem_bus_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .ic_command        (ic_command),
        .ic_addr           (ic_addr),
        .dc_command        (dc_command),
        .dc_addr           (dc_addr),
        .dc_data           (dc_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .ic_response       (ic_response),
        .dc_response       (dc_response),
        .ic_tag            (ic_tag),
        .dc_tag            (dc_tag),
        .ret_data          (ret_data),
        .stray_tag         (stray_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  icr, dcr, ict, dct;
        logic [63:0] rd;
        logic        stray;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference state: who owns each tag (0 none, 1 ic, 2 dc) and who was last accepted.
    int own[16];
    int last_w = 2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare all outputs mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("proc2mem_command", 64'(proc2mem_command), 64'(e.cmd));
            chk("proc2mem_addr", 64'(proc2mem_addr), 64'(e.addr));
            chk("proc2mem_data", proc2mem_data, e.data);
            chk("ic_response", 64'(ic_response), 64'(e.icr));
            chk("dc_response", 64'(dc_response), 64'(e.dcr));
            chk("ic_tag", 64'(ic_tag), 64'(e.ict));
            chk("dc_tag", 64'(dc_tag), 64'(e.dct));
            chk("ret_data", ret_data, e.rd);
            chk("stray_tag", 64'(stray_tag), 64'(e.stray));
        end
    end

    // Apply one cycle of inputs, predict the outputs from the bus rules, advance the model.
    task automatic cyc(input logic rst, input logic [1:0] icc, input logic [31:0] ica,
                       input logic [1:0] dcc, input logic [31:0] dca, input logic [63:0] dcd,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
        exp_t e;
        int   ic_n, dc_n, w;
        bit   ic_ok, dc_ok;
        @(posedge clock);
        #1;
        reset = rst; ic_command = icc; ic_addr = ica; dc_command = dcc; dc_addr = dca;
        dc_data = dcd; mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdata;
        e = '{cmd: BUS_NONE, addr: '0, data: '0, icr: '0, dcr: '0, ict: '0, dct: '0,
              rd: '0, stray: 1'b0};
        if (rst) begin
            foreach (own[i]) own[i] = 0;
            last_w = 2;
        end else begin
            ic_n = 0; dc_n = 0;
            foreach (own[i]) begin
                if (own[i] == 1) ic_n++;
                if (own[i] == 2) dc_n++;
            end
            ic_ok = (icc == BUS_LOAD) && (ic_n < IC_MAX);
            dc_ok = (dcc == BUS_STORE) || ((dcc == BUS_LOAD) && (dc_n < DC_MAX));
            w = 0;
            if (dcc == BUS_STORE) w = 2;
            else if (ic_ok && dc_ok) w = (last_w == 2) ? 1 : 2;
            else if (ic_ok) w = 1;
            else if (dc_ok) w = 2;
            if (w == 1) begin e.cmd = icc; e.addr = ica; e.icr = resp; end
            if (w == 2) begin e.cmd = dcc; e.addr = dca; e.data = dcd; e.dcr = resp; end
            e.rd = rdata;
            if (rtag != 0) begin
                if (own[rtag] == 1) e.ict = rtag;
                else if (own[rtag] == 2) e.dct = rtag;
                else e.stray = 1'b1;
                own[rtag] = 0;
            end
            if (w != 0 && resp != 0) begin
                last_w = w;
                if (e.cmd == BUS_LOAD) own[resp] = w;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [3:0] rtag, input logic [63:0] rdata);
        cyc(1'b0, BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, rtag, rdata);
    endtask

    initial begin
        int        owned[$];
        int        freel[$];
        logic [1:0] icc, dcc;
        logic [3:0] rtag, resp;
        int         r;

        foreach (own[i]) own[i] = 0;
        cyc(1'b1, BUS_LOAD, 32'h100, BUS_LOAD, 32'h200, 64'h0, 4'd3, 4'd2, 64'h55);
        cyc(1'b1, BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, 4'd0, 64'h0);

        // Load tie: ic first, then dc on the next tie.
        cyc(1'b0, BUS_LOAD, 32'h100, BUS_LOAD, 32'h200, 64'h0, 4'd3, 4'd0, 64'h0);
        cyc(1'b0, BUS_LOAD, 32'h100, BUS_LOAD, 32'h200, 64'h0, 4'd4, 4'd0, 64'h0);
        // Store beats an ic load and allocates no tag.
        cyc(1'b0, BUS_LOAD, 32'h400, BUS_STORE, 32'h300, 64'hDEADBEEF, 4'd5, 4'd0, 64'h0);
        idle(4'd5, 64'h77);
        // dc load round trip.
        cyc(1'b0, BUS_NONE, '0, BUS_LOAD, 32'h500, 64'h0, 4'd7, 4'd0, 64'h0);
        idle(4'd0, 64'h0);
        idle(4'd7, 64'h1234);
        idle(4'd3, 64'h33);
        idle(4'd4, 64'h44);
        // ic throttle at eight outstanding loads.
        for (int t = 1; t <= 8; t++)
            cyc(1'b0, BUS_LOAD, 32'h1000 + 32'(t), BUS_NONE, '0, '0, 4'(t), 4'd0, 64'h0);
        cyc(1'b0, BUS_LOAD, 32'h1009, BUS_LOAD, 32'h600, 64'h0, 4'd9, 4'd0, 64'h0);
        cyc(1'b0, BUS_LOAD, 32'h1009, BUS_NONE, '0, '0, 4'd0, 4'd1, 64'h11);
        cyc(1'b0, BUS_LOAD, 32'h1009, BUS_NONE, '0, '0, 4'd1, 4'd0, 64'h0);
        // Same-cycle return and reallocation of tag 2.
        cyc(1'b0, BUS_NONE, '0, BUS_LOAD, 32'h700, 64'h0, 4'd2, 4'd2, 64'h22);
        idle(4'd2, 64'h2222);
        // Reset with loads outstanding; later returns are strays and counters are clear.
        cyc(1'b1, BUS_LOAD, 32'h800, BUS_LOAD, 32'h900, 64'h0, 4'd10, 4'd3, 64'h0);
        idle(4'd3, 64'h3);
        for (int t = 1; t <= 9; t++)
            cyc(1'b0, BUS_LOAD, 32'h2000 + 32'(t), BUS_NONE, '0, '0, 4'(t), 4'd0, 64'h0);
        for (int t = 1; t <= 8; t++) idle(4'(t), 64'(t));

        // Randomized traffic against a memory that only hands out free tags.
        for (int n = 0; n < 2000; n++) begin
            owned.delete();
            freel.delete();
            for (int t = 1; t <= 15; t++) if (own[t] != 0) owned.push_back(t);
            r = int'($urandom_range(0, 99));
            if (r < 40 && owned.size() > 0)
                rtag = 4'(owned[$urandom_range(0, owned.size() - 1)]);
            else if (r < 45) rtag = 4'($urandom_range(1, 15));
            else rtag = 4'd0;
            for (int t = 1; t <= 15; t++)
                if (own[t] == 0 || t == int'(rtag)) freel.push_back(t);
            if ($urandom_range(0, 99) < 20 || freel.size() == 0) resp = 4'd0;
            else resp = 4'(freel[$urandom_range(0, freel.size() - 1)]);
            icc = ($urandom_range(0, 99) < 60) ? BUS_LOAD : BUS_NONE;
            r = int'($urandom_range(0, 99));
            dcc = (r < 15) ? BUS_STORE : ((r < 55) ? BUS_LOAD : BUS_NONE);
            cyc(($urandom_range(0, 99) == 0), icc, $urandom, dcc, $urandom,
                {$urandom, $urandom}, resp, rtag, {$urandom, $urandom});
        end

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
